count_bcd_display: RTL and testbench

COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

---
 rtl/count_disp_pkg.sv | 31 +++
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/count_bcd_display.sv | 136 +++++++++++++
 tb/tb_count_bcd_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared types and constants for the BCD count display
// Holds the converter FSM state encoding, the digit count, the active-low
// segment patterns ({g,f,e,d,c,b,a}) and the double-dabble nibble adjust.
package count_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Pre-shift correction: a nibble >= 5 would exceed 9 after doubling.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
// Ports:
//   digit  in  4  BCD digit 0..9 (codes 10..15 decode to blank)
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import count_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - 8-bit count to BCD converter with 3-digit multiplexed display
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high reset
//   count_in   in  8   unsigned count to display
//   bcd        out 12  registered BCD {hundreds, tens, ones}
//   bcd_valid  out 1   one-cycle pulse when bcd updates
//   busy       out 1   conversion in progress
//   seg        out 7   active-low segments {g,f,e,d,c,b,a}
//   an         out 3   active-low one-hot digit enable (an[0] = ones)
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

  state_t      state;
  logic [7:0]  captured;
  logic [7:0]  bin_sh;
  logic [11:0] work;
  logic [2:0]  bit_cnt;
  logic [19:0] dd_next;

  // One double-dabble step: correct every nibble, then shift the whole
  // {bcd, binary} register left so the binary MSB enters the ones nibble.
  assign dd_next = {add3_if_ge5(work[11:8]), add3_if_ge5(work[7:4]),
                    add3_if_ge5(work[3:0]), bin_sh} << 1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      captured  <= 8'd0;
      bin_sh    <= 8'd0;
      work      <= 12'd0;
      bit_cnt   <= 3'd0;
      bcd       <= 12'd0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (count_in != captured) begin
            captured <= count_in;
            bin_sh   <= count_in;
            work     <= 12'd0;
            bit_cnt  <= 3'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= dd_next[19:8];
          bin_sh  <= dd_next[7:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd       <= work;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan: free-running, independent of the converter.
  logic [PW-1:0] presc;
  logic [1:0]    digit_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc     <= '0;
      digit_idx <= (digit_idx == LAST_DIGIT) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  logic [3:0] sel_digit;
  logic [2:0] an_next;
  logic [6:0] dec_seg;
  logic       blank;

  always_comb begin
    sel_digit = bcd[3:0];
    an_next   = 3'b110;
    case (digit_idx)
      2'd1: begin sel_digit = bcd[7:4];  an_next = 3'b101; end
      2'd2: begin sel_digit = bcd[11:8]; an_next = 3'b011; end
      default: begin sel_digit = bcd[3:0]; an_next = 3'b110; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Tens is only a leading zero when hundreds is zero as well.
  assign blank = ((digit_idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
                 ((digit_idx == 2'd1) && (bcd[11:4] == 8'd0));
`else
  assign blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 3'b111;
    end else begin
      seg <= blank ? SEG_BLANK : dec_seg;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - scoreboard bench for count_bcd_display
module tb_count_bcd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count_in;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int pushes = 0;
  int model_last = 0;
  logic prev_valid = 1'b0;
  logic [11:0] exp_q[$];

  count_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // pos 0 = ones, 1 = tens, 2 = hundreds
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int d;
    d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 2 && v < 100) return 7'b1111111;
    if (pos == 1 && v < 10)  return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  task automatic push(input int v);
    exp_q.push_back(to_bcd(v));
    pushes++;
  endtask

  // Drive a new count; a conversion is expected only when it differs from
  // the value the converter last accepted.
  task automatic apply(input int v);
    count_in = 8'(v);
    if (v != model_last) begin
      push(v);
      model_last = v;
    end
  endtask

  // Monitor: every bcd_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bcd_valid) begin
        pulses++;
        check("valid_width", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got bcd %0h expected no pulse", bcd);
        end else begin
          check("bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
        end
      end
      prev_valid = bcd_valid;
    end
  end

  // Align to the start of the ones step, then check three scan steps.
  task automatic scan_check(input int v);
    logic [2:0] prev;
    logic [2:0] exp_an [3];
    int dur;
    bit found;
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      prev = an;
      @(negedge clk);
      if (an == 3'b110 && prev != 3'b110) found = 1;
    end
    check("scan_align", {31'd0, found}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      check("an_step", {29'd0, an}, {29'd0, exp_an[s]});
      check("seg_step", {25'd0, seg}, {25'd0, exp_seg(v, s)});
      dur = 0;
      while (an == exp_an[s] && dur < 20) begin
        dur++;
        @(negedge clk);
      end
      check("step_len", dur, 4);
    end
  endtask

  initial begin
    int busy_cnt, valid_at, p0, v;
    bit done;

    reset = 1'b1;
    count_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    check("rst_valid", {31'd0, bcd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_seg", {25'd0, seg}, 32'h7f);
    check("rst_an", {29'd0, an}, 32'h7);
    reset = 1'b0;
    @(negedge clk);
    check("an_first", {29'd0, an}, 32'b110);
    repeat (5) @(negedge clk);
    check("idle_zero_busy", {31'd0, busy}, 32'd0);

    // 255: busy for 9 cycles, bcd update on the 10th sample
    apply(255);
    busy_cnt = 0;
    valid_at = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bcd_valid && valid_at == 0) valid_at = k;
    end
    check("busy_len", busy_cnt, 9);
    check("latency", valid_at, 10);
    check("bcd_255", {20'd0, bcd}, 32'h255);

    // 173 then 174 applied mid-conversion
    p0 = pulses;
    apply(173);
    repeat (3) @(negedge clk);
    apply(174);
    repeat (25) @(negedge clk);
    check("two_pulses", pulses - p0, 2);
    check("bcd_174", {20'd0, bcd}, 32'h174);

    // display scan
    apply(42);
    repeat (12) @(negedge clk);
    scan_check(42);
    apply(7);
    repeat (12) @(negedge clk);
    scan_check(7);

    // reset at edge N+4 of a 200 conversion
    count_in = 8'd200;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bcd", {20'd0, bcd}, 32'h000);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, bcd_valid}, 32'd0);
    @(negedge clk);
    model_last = 0;
    p0 = pulses;
    apply(200);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("bcd_200", {20'd0, bcd}, 32'h200);
    check("one_pulse_200", pulses - p0, 1);

    // full sweep at the minimum restart interval
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      apply(i);
      repeat (10) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("sweep_pulses", pulses - p0, 256);

    // random values, with repeats that must not trigger a conversion
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) v = model_last;
      else v = int'($urandom_range(0, 255));
      apply(v);
      repeat ($urandom_range(10, 14)) @(negedge clk);
    end

    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (exp_q.size() == 0) done = 1;
      else @(negedge clk);
    end
    check("queue_drained", exp_q.size(), 0);
    check("pulse_total", pulses, pushes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
